// File: rtl/udp_sample_rx.sv
// udp_sample_rx: GMII receive-side Ethernet/IPv4/UDP parser.
// Strips headers addressed to this board, emits the payload as big-endian
// 32-bit samples, checks the FCS and reports per-frame status.
module udp_sample_rx #(
   parameter logic [47:0] LOCAL_MAC = 48'h000A35010203,
   parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0002,
   parameter logic [15:0] UDP_PORT  = 16'd8080
) (
   input  logic        gmii_rx_clk,
   input  logic        rst_n,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic [31:0] sample_data,
   output logic        sample_valid,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [15:0] sample_cnt,
   output logic [15:0] drop_cnt
);

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_ETH_HDR,
      S_IP_HDR,
      S_UDP_HDR,
      S_PAYLOAD,
      S_TRAILER,
      S_DROP
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;                 // byte index inside the current field group
   logic [39:0] hdr_q, hdr_d;                 // last five bytes seen, oldest in the MSBs
   logic [15:0] payload_len_q, payload_len_d;
   logic [31:0] crc_q, crc_d;
   logic        bad_q, bad_d;                 // a header field mismatched in this frame
   logic        in_frame_q, in_frame_d;       // SFD seen, so dv falling ends a frame
   logic        armed_q, armed_d;             // dv has been low since reset
   logic [31:0] sample_data_q, sample_data_d;
   logic        sample_valid_q, sample_valid_d;
   logic [15:0] sample_cnt_q, sample_cnt_d;
   logic        frame_done_q, frame_done_d;
   logic        frame_ok_q, frame_ok_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Multi-byte fields ending on the byte currently on the bus
   logic [47:0] field48;
   logic [31:0] field32;
   logic [15:0] field16;
   logic        frame_good;

   assign field48    = {hdr_q, gmii_rxd};
   assign field32    = field48[31:0];
   assign field16    = field48[15:0];
   assign frame_good = !bad_q && (state_q == S_TRAILER) && (crc_q == CRC_RESIDUE);

   // Reflected CRC-32 (0x04C11DB7), one byte LSB first
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   // Next-state, header checks, sample packing and end-of-frame status
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      hdr_d          = hdr_q;
      payload_len_d  = payload_len_q;
      crc_d          = crc_q;
      bad_d          = bad_q;
      in_frame_d     = in_frame_q;
      armed_d        = armed_q | ~gmii_rx_dv;
      sample_data_d  = sample_data_q;
      sample_valid_d = 1'b0;
      sample_cnt_d   = sample_cnt_q;
      frame_done_d   = 1'b0;
      frame_ok_d     = frame_ok_q;
      drop_cnt_d     = drop_cnt_q;

      case (state_q)
         S_IDLE, S_PREAMBLE: begin
            if (!gmii_rx_dv) begin
               state_d = S_IDLE;
            end else if (state_q == S_PREAMBLE || armed_q) begin
               if (gmii_rxd == 8'h55) begin
                  state_d = S_PREAMBLE;
               end else if (gmii_rxd == 8'hD5) begin
                  state_d      = S_ETH_HDR;
                  crc_d        = CRC_INIT;
                  cnt_d        = 16'd0;
                  bad_d        = 1'b0;
                  in_frame_d   = 1'b1;
                  sample_cnt_d = 16'd0;
               end else begin
                  state_d = S_DROP;
               end
            end
         end
         default: begin
            if (!gmii_rx_dv) begin
               state_d    = S_IDLE;
               in_frame_d = 1'b0;
               if (in_frame_q) begin
                  frame_done_d = 1'b1;
                  frame_ok_d   = frame_good;
                  if (!frame_good && drop_cnt_q != 16'hFFFF) begin
                     drop_cnt_d = drop_cnt_q + 16'd1;
                  end
               end
            end else if (in_frame_q) begin
               crc_d = crc_byte(crc_q, gmii_rxd);
               hdr_d = field48[39:0];
               cnt_d = cnt_q + 16'd1;
               case (state_q)
                  S_ETH_HDR: begin
                     if (cnt_q == 16'd5 && field48 != LOCAL_MAC && field48 != 48'hFFFF_FFFF_FFFF) begin
                        bad_d   = 1'b1;
                        state_d = S_DROP;
                     end else if (cnt_q == 16'd13) begin
                        if (field16 != 16'h0800) begin
                           bad_d   = 1'b1;
                           state_d = S_DROP;
                        end else begin
                           state_d = S_IP_HDR;
                           cnt_d   = 16'd0;
                        end
                     end
                  end
                  S_IP_HDR: begin
                     if ((cnt_q == 16'd0 && gmii_rxd != 8'h45) ||
                         (cnt_q == 16'd9 && gmii_rxd != 8'h11)) begin
                        bad_d   = 1'b1;
                        state_d = S_DROP;
                     end else if (cnt_q == 16'd19) begin
                        if (field32 != LOCAL_IP) begin
                           bad_d   = 1'b1;
                           state_d = S_DROP;
                        end else begin
                           state_d = S_UDP_HDR;
                           cnt_d   = 16'd0;
                        end
                     end
                  end
                  S_UDP_HDR: begin
                     if (cnt_q == 16'd3 && field16 != UDP_PORT) begin
                        bad_d   = 1'b1;
                        state_d = S_DROP;
                     end else if (cnt_q == 16'd5) begin
                        if (field16 < 16'd8) begin
                           bad_d   = 1'b1;
                           state_d = S_DROP;
                        end else begin
                           payload_len_d = field16 - 16'd8;
                        end
                     end else if (cnt_q == 16'd7) begin
                        cnt_d   = 16'd0;
                        state_d = (payload_len_q == 16'd0) ? S_TRAILER : S_PAYLOAD;
                     end
                  end
                  S_PAYLOAD: begin
                     // hdr_q doubles as the sample shift register
                     if (cnt_q[1:0] == 2'b11) begin
                        sample_data_d  = field32;
                        sample_valid_d = 1'b1;
                        sample_cnt_d   = sample_cnt_q + 16'd1;
                     end
                     if (cnt_q + 16'd1 == payload_len_q) begin
                        state_d = S_TRAILER;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= 16'd0;
         hdr_q          <= 40'd0;
         payload_len_q  <= 16'd0;
         crc_q          <= CRC_INIT;
         bad_q          <= 1'b0;
         in_frame_q     <= 1'b0;
         armed_q        <= 1'b0;
         sample_data_q  <= 32'd0;
         sample_valid_q <= 1'b0;
         sample_cnt_q   <= 16'd0;
         frame_done_q   <= 1'b0;
         frame_ok_q     <= 1'b0;
         drop_cnt_q     <= 16'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         hdr_q          <= hdr_d;
         payload_len_q  <= payload_len_d;
         crc_q          <= crc_d;
         bad_q          <= bad_d;
         in_frame_q     <= in_frame_d;
         armed_q        <= armed_d;
         sample_data_q  <= sample_data_d;
         sample_valid_q <= sample_valid_d;
         sample_cnt_q   <= sample_cnt_d;
         frame_done_q   <= frame_done_d;
         frame_ok_q     <= frame_ok_d;
         drop_cnt_q     <= drop_cnt_d;
      end
   end

   assign sample_data  = sample_data_q;
   assign sample_valid = sample_valid_q;
   assign sample_cnt   = sample_cnt_q;
   assign frame_done   = frame_done_q;
   assign frame_ok     = frame_ok_q;
   assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_udp_sample_rx.sv
// tb_udp_sample_rx: frame generator plus scoreboard for udp_sample_rx.
// Frames are built byte by byte; expected samples and frame status are
// derived from the frame contents and pushed to queues before driving.
module tb_udp_sample_rx;

   localparam logic [47:0] LOCAL_MAC = 48'h000A35010203;
   localparam logic [31:0] LOCAL_IP  = 32'hC0A8_0002;
   localparam logic [15:0] UDP_PORT  = 16'd8080;

   logic        gmii_rx_clk = 1'b0;
   logic        rst_n       = 1'b0;
   logic        gmii_rx_dv  = 1'b0;
   logic [7:0]  gmii_rxd    = 8'd0;
   logic [31:0] sample_data;
   logic        sample_valid;
   logic        frame_done;
   logic        frame_ok;
   logic [15:0] sample_cnt;
   logic [15:0] drop_cnt;

   udp_sample_rx #(
      .LOCAL_MAC(LOCAL_MAC),
      .LOCAL_IP (LOCAL_IP),
      .UDP_PORT (UDP_PORT)
   ) dut (
      .gmii_rx_clk (gmii_rx_clk),
      .rst_n       (rst_n),
      .gmii_rx_dv  (gmii_rx_dv),
      .gmii_rxd    (gmii_rxd),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .frame_done  (frame_done),
      .frame_ok    (frame_ok),
      .sample_cnt  (sample_cnt),
      .drop_cnt    (drop_cnt)
   );

   always #4 gmii_rx_clk = ~gmii_rx_clk;

   typedef struct {
      logic [31:0] data;
      logic [15:0] cnt;
   } samp_t;

   typedef struct {
      logic        ok;
      logic [15:0] scnt;
      logic [15:0] dcnt;
   } frm_t;

   samp_t      exp_s[$];
   frm_t       exp_f[$];
   logic [7:0] tx_bytes[$];
   int         compared   = 0;
   int         mismatched = 0;
   int         model_drop = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: pop and compare whenever the DUT strobes an output
   always @(negedge gmii_rx_clk) begin
      if (rst_n) begin
         if (sample_valid) begin
            samp_t e;
            if (exp_s.size() == 0) begin
               check("unexpected sample_valid", {31'd0, sample_valid}, 32'd0);
            end else begin
               e = exp_s.pop_front();
               $display("sample: data=%h cnt=%0d (expect %h/%0d)", sample_data, sample_cnt, e.data, e.cnt);
               check("sample_data", sample_data, e.data);
               check("sample_cnt", {16'd0, sample_cnt}, {16'd0, e.cnt});
            end
         end
         if (frame_done) begin
            frm_t f;
            if (exp_f.size() == 0) begin
               check("unexpected frame_done", {31'd0, frame_done}, 32'd0);
            end else begin
               f = exp_f.pop_front();
               $display("frame: ok=%0d samples=%0d drops=%0d (expect %0d/%0d/%0d)",
                        frame_ok, sample_cnt, drop_cnt, f.ok, f.scnt, f.dcnt);
               check("frame_ok", {31'd0, frame_ok}, {31'd0, f.ok});
               check("frame sample_cnt", {16'd0, sample_cnt}, {16'd0, f.scnt});
               check("drop_cnt", {16'd0, drop_cnt}, {16'd0, f.dcnt});
            end
         end
      end
   end

   // Build one frame into tx_bytes and push the expected response.
   // trunc >= 0 keeps only that many bytes after the SFD.
   task automatic build_frame(input int pre_len, input bit bad_pre,
                              input logic [47:0] mac, input logic [15:0] etype,
                              input logic [7:0] ver, input logic [7:0] proto,
                              input logic [31:0] dip, input logic [15:0] port,
                              input logic [15:0] ulen, input bit seq,
                              input bit corrupt, input int trunc);
      logic [7:0]  body[$];
      logic [7:0]  pay[$];
      logic [31:0] c;
      logic [15:0] tot;
      int          plen, nrx, npay, ns;
      bit          hdr_ok, ok, fb;
      samp_t       s;
      frm_t        f;

      plen = (ulen >= 16'd8) ? int'(ulen) - 8 : 0;
      for (int i = 0; i < plen; i++) pay.push_back(seq ? 8'(i) : 8'($urandom));
      tot = 16'd20 + ulen;

      for (int i = 5; i >= 0; i--) body.push_back(mac[i*8 +: 8]);
      body.push_back(8'h02); body.push_back(8'h00); body.push_back(8'h00);
      body.push_back(8'h00); body.push_back(8'h00); body.push_back(8'h01);
      body.push_back(etype[15:8]); body.push_back(etype[7:0]);
      body.push_back(ver);  body.push_back(8'h00);
      body.push_back(tot[15:8]); body.push_back(tot[7:0]);
      body.push_back(8'h00); body.push_back(8'h00);
      body.push_back(8'h40); body.push_back(8'h00);
      body.push_back(8'h40); body.push_back(proto);
      body.push_back(8'h00); body.push_back(8'h00);
      body.push_back(8'hC0); body.push_back(8'hA8); body.push_back(8'h00); body.push_back(8'h01);
      for (int i = 3; i >= 0; i--) body.push_back(dip[i*8 +: 8]);
      body.push_back(8'h12); body.push_back(8'h34);
      body.push_back(port[15:8]); body.push_back(port[7:0]);
      body.push_back(ulen[15:8]); body.push_back(ulen[7:0]);
      body.push_back(8'h00); body.push_back(8'h00);
      foreach (pay[i]) body.push_back(pay[i]);
      while (body.size() < 60) body.push_back(8'h00);

      c = 32'hFFFF_FFFF;
      foreach (body[i]) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ body[i][j];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
         end
      end
      c = ~c;
      for (int i = 0; i < 4; i++) body.push_back(c[i*8 +: 8]);
      if (corrupt) body[body.size()-2] = body[body.size()-2] ^ 8'h04;
      nrx = body.size();
      if (trunc >= 0) begin
         while (body.size() > trunc) void'(body.pop_back());
         nrx = trunc;
      end

      for (int i = 0; i < pre_len; i++) tx_bytes.push_back((bad_pre && i == 1) ? 8'h5A : 8'h55);
      tx_bytes.push_back(8'hD5);
      foreach (body[i]) tx_bytes.push_back(body[i]);

      if (bad_pre) return;

      hdr_ok = (mac == LOCAL_MAC || mac == 48'hFFFF_FFFF_FFFF) && etype == 16'h0800 &&
               ver == 8'h45 && proto == 8'h11 && dip == LOCAL_IP &&
               port == UDP_PORT && ulen >= 16'd8;
      npay = 0;
      if (hdr_ok) begin
         npay = nrx - 42;
         if (npay < 0) npay = 0;
         if (npay > plen) npay = plen;
      end
      ns = npay / 4;
      for (int k = 0; k < ns; k++) begin
         s.data = {pay[4*k], pay[4*k+1], pay[4*k+2], pay[4*k+3]};
         s.cnt  = 16'(k + 1);
         exp_s.push_back(s);
      end
      ok = hdr_ok && !corrupt && trunc < 0;
      if (!ok && model_drop < 65535) model_drop++;
      f.ok   = ok;
      f.scnt = 16'(ns);
      f.dcnt = 16'(model_drop);
      exp_f.push_back(f);
   endtask

   task automatic drive_tx(input int gap);
      for (int i = 0; i < tx_bytes.size(); i++) begin
         @(posedge gmii_rx_clk);
         #2;
         gmii_rx_dv = 1'b1;
         gmii_rxd   = tx_bytes[i];
      end
      @(posedge gmii_rx_clk);
      #2;
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'd0;
      repeat (gap - 1) @(posedge gmii_rx_clk);
      tx_bytes.delete();
   endtask

   task automatic good_frame(input int plen, input bit seq, input bit corrupt);
      build_frame(7, 1'b0, LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, UDP_PORT,
                  16'(plen + 8), seq, corrupt, -1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          kind, plen, gap, pre;
      logic [47:0] mac;
      logic [15:0] etype, port, ulen;
      logic [7:0]  ver, proto;
      logic [31:0] dip;
      bit          corrupt, bad_pre;
      int          trunc;

      // Reset state
      repeat (3) @(posedge gmii_rx_clk);
      #1;
      check("reset sample_valid", {31'd0, sample_valid}, 32'd0);
      check("reset frame_done", {31'd0, frame_done}, 32'd0);
      check("reset frame_ok", {31'd0, frame_ok}, 32'd0);
      check("reset sample_cnt", {16'd0, sample_cnt}, 32'd0);
      check("reset drop_cnt", {16'd0, drop_cnt}, 32'd0);
      check("reset sample_data", sample_data, 32'd0);
      @(posedge gmii_rx_clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge gmii_rx_clk);

      // Valid 16-byte payload, then the same with a flipped FCS bit
      good_frame(16, 1'b1, 1'b0);
      drive_tx(3);
      good_frame(16, 1'b1, 1'b1);
      drive_tx(3);
      // Wrong UDP port
      build_frame(7, 1'b0, LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, 16'd8081,
                  16'd24, 1'b1, 1'b0, -1);
      drive_tx(3);
      // 6 payload bytes padded to minimum frame size
      good_frame(6, 1'b1, 1'b0);
      drive_tx(3);
      // dv drops in the IP header, next frame one cycle later
      build_frame(7, 1'b0, LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, UDP_PORT,
                  16'd24, 1'b1, 1'b0, 20);
      drive_tx(1);
      good_frame(16, 1'b1, 1'b0);
      drive_tx(3);

      // Reset in the middle of the payload: only the first two samples appear
      good_frame(16, 1'b1, 1'b0);
      void'(exp_f.pop_back());
      void'(exp_s.pop_back());
      void'(exp_s.pop_back());
      for (int i = 0; i < tx_bytes.size(); i++) begin
         @(posedge gmii_rx_clk);
         #2;
         gmii_rx_dv = 1'b1;
         gmii_rxd   = tx_bytes[i];
         if (i == 60) begin
            rst_n = 1'b0;
            #1;
            check("midreset sample_valid", {31'd0, sample_valid}, 32'd0);
            check("midreset frame_ok", {31'd0, frame_ok}, 32'd0);
            check("midreset sample_cnt", {16'd0, sample_cnt}, 32'd0);
            check("midreset drop_cnt", {16'd0, drop_cnt}, 32'd0);
            check("midreset sample_data", sample_data, 32'd0);
         end
         if (i == 61) rst_n = 1'b1;
      end
      tx_bytes.delete();
      model_drop = 0;
      @(posedge gmii_rx_clk);
      #2;
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'd0;
      good_frame(16, 1'b1, 1'b0);
      drive_tx(2);

      // Randomized frames
      for (int n = 0; n < 40; n++) begin
         kind    = $urandom_range(0, 11);
         plen    = $urandom_range(0, 40);
         gap     = $urandom_range(1, 3);
         pre     = $urandom_range(3, 7);
         mac     = LOCAL_MAC;
         etype   = 16'h0800;
         ver     = 8'h45;
         proto   = 8'h11;
         dip     = LOCAL_IP;
         port    = UDP_PORT;
         ulen    = 16'(plen + 8);
         corrupt = 1'b0;
         bad_pre = 1'b0;
         trunc   = -1;
         case (kind)
            1:  mac = 48'hFFFF_FFFF_FFFF;
            2:  mac = LOCAL_MAC ^ (48'd1 << $urandom_range(0, 47));
            3:  etype = 16'h0800 ^ (16'd1 << $urandom_range(0, 15));
            4:  ver = 8'h45 ^ (8'd1 << $urandom_range(0, 7));
            5:  proto = 8'h11 ^ (8'd1 << $urandom_range(0, 7));
            6:  dip = LOCAL_IP ^ (32'd1 << $urandom_range(0, 31));
            7:  port = UDP_PORT ^ (16'd1 << $urandom_range(0, 15));
            8:  ulen = 16'($urandom_range(0, 7));
            9:  corrupt = 1'b1;
            10: trunc = $urandom_range(1, 41 + plen);
            11: bad_pre = 1'b1;
            default: ;
         endcase
         build_frame(pre, bad_pre, mac, etype, ver, proto, dip, port, ulen,
                     1'b0, corrupt, trunc);
         drive_tx(gap);
      end

      repeat (10) @(posedge gmii_rx_clk);
      check("samples outstanding", exp_s.size(), 32'd0);
      check("frames outstanding", exp_f.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/udp_sample_rx.md
# udp_sample_rx

Receive-side counterpart of the FM-sample UDP streamer. Sits on the GMII receive path after the GMII/RGMII converter and accepts Ethernet/IPv4/UDP frames addressed to this board. It strips the headers, emits the payload as 32-bit big-endian samples, and checks the frame CRC. It also reports per-frame status so a downstream consumer (loopback checker or DAC feed) can discard samples from bad frames.

## Interface
Parameters:
- LOCAL_MAC, 48'h000A35010203: accepted destination MAC; broadcast FF:FF:FF:FF:FF:FF is also accepted.
- LOCAL_IP, 32'hC0A8_0002: accepted destination IPv4 address.
- UDP_PORT, 16'd8080: accepted UDP destination port.

Ports:
- gmii_rx_clk, in, 1: receive clock, 125 MHz; the only clock.
- rst_n, in, 1: asynchronous, active-low reset.
- gmii_rx_dv, in, 1: receive data valid.
- gmii_rxd, in, 8: receive byte.
- sample_data, out, 32: extracted sample. The first payload byte maps to [31:24].
- sample_valid, out, 1: one-cycle strobe qualifying sample_data.
- frame_done, out, 1: one-cycle strobe at end of every frame that passed SFD.
- frame_ok, out, 1: status of the frame ending at frame_done; held until the next frame_done.
- sample_cnt, out, 16: samples emitted in the current or last frame. Cleared at SFD.
- drop_cnt, out, 16: count of frames ending with frame_ok=0. Saturates at 16'hFFFF.

## Operation
- All outputs reset to 0. The FSM resets to IDLE and the CRC register resets to 32'hFFFFFFFF.
- FSM states and transitions:
  - IDLE: wait for gmii_rx_dv=1.
  - PREAMBLE: bytes of 0x55 are skipped. 0xD5 moves to ETH_HDR and reinitialises CRC and byte counter. Any other byte moves to DROP with no frame_done.
  - ETH_HDR, 14 bytes: dest MAC must equal LOCAL_MAC or broadcast; EtherType must be 0x0800.
  - IP_HDR, 20 bytes: byte0 must be 0x45; protocol (byte 9) must be 0x11; dest IP (bytes 16–19) must equal LOCAL_IP. The IP checksum is not checked.
  - UDP_HDR, 8 bytes: dest port (bytes 2–3) must equal UDP_PORT. UDP length (bytes 4–5) must be ≥ 8; payload length = UDP length − 8.
  - PAYLOAD: bytes are packed into a 32-bit shift register and a sample is emitted on every 4th byte. After the payload length is reached, go to TRAILER. A payload length of 0 goes straight to TRAILER.
  - TRAILER: padding and FCS bytes feed the CRC only.
  - DROP: ignore bytes until gmii_rx_dv=0.
- Header checks:
  - A field mismatch sets an internal bad flag and moves to DROP immediately. The CRC keeps running, so frame_done still fires.
  - The check is evaluated on the last byte of the field.
- CRC: CRC-32, polynomial 0x04C11DB7, reflected, init 32'hFFFFFFFF. It covers every byte after SFD including the 4 FCS bytes. The CRC is good iff the register equals 32'hDEBB20E3 when gmii_rx_dv falls.
- End of frame: on gmii_rx_dv 1→0 in any state past PREAMBLE, return to IDLE and generate frame_done.
- frame_ok=1 only if all of the following hold:
  - all header checks passed;
  - the full payload was received, i.e. the frame ended in TRAILER;
  - the CRC is good.
- Trailing payload bytes (payload length mod 4) are discarded with no partial sample.
- Samples are emitted as soon as they are assembled, before CRC is known. The consumer must gate them with frame_ok.
- gmii_rx_dv falling in PREAMBLE or IDLE gives no frame_done and no drop count.
- Only 1000 Mb/s, full-duplex, one byte per clock is supported.

## Timing
- sample_valid is registered and asserts the cycle after the 4th byte of each sample is sampled. sample_data is stable only while sample_valid=1.
- Minimum spacing between sample_valid strobes is 4 cycles.
- sample_cnt increments in the same cycle sample_valid asserts.
- frame_done, frame_ok and drop_cnt update in the cycle after the first cycle where gmii_rx_dv=0. Latency from the last FCS byte to frame_done is 1 cycle.
- Back-to-back frames need no inter-frame gap beyond one dv-low cycle. The next SFD may arrive 1 cycle after dv falls.
- rst_n asserted mid-frame clears everything at once. After release, the FSM waits in IDLE: bytes already in flight with gmii_rx_dv=1 must not be parsed; parsing resumes only after gmii_rx_dv has been seen low.

## Test plan
- Valid frame, 7×0x55 + 0xD5, matching headers, UDP length 24 (16 payload bytes 00..0F), correct FCS -> 4 strobes: 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F; then frame_done with frame_ok=1 and sample_cnt=4.
- Same frame with one FCS bit flipped -> the same 4 samples; frame_done with frame_ok=0; drop_cnt increments by 1.
- Wrong UDP port (8081), correct FCS -> no sample_valid; frame_done with frame_ok=0; drop_cnt+1.
- UDP length 14 (6 payload bytes) padded to a 60-byte frame -> 1 sample 0x00010203, the remaining 2 bytes are dropped, frame_ok=1, sample_cnt=1.
- gmii_rx_dv drops in the middle of IP_HDR -> frame_done with frame_ok=0. A following valid frame 1 cycle later is received correctly.
- rst_n pulsed during PAYLOAD -> outputs go to 0 at once. The remainder of that frame is ignored and the next frame is parsed normally.
